// File: rtl/bp_pkg.sv
// Shared helpers for the branch history table: counter reset value, saturating
// counter step and table index hashing.
package bp_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic [MAX_W-1:0] bp_word_t;

    // Weakly not-taken: 2^(ctr_bits-1)-1, which collapses to 0 for 1-bit counters.
    function automatic bp_word_t ctr_init(input int unsigned ctr_bits);
        return (bp_word_t'(1) << (ctr_bits - 1)) - bp_word_t'(1);
    endfunction

    function automatic bp_word_t sat_ctr_next(
        input bp_word_t    ctr,
        input logic        taken,
        input int unsigned ctr_bits
    );
        bp_word_t ctr_max;
        bp_word_t result;
        ctr_max = (bp_word_t'(1) << ctr_bits) - bp_word_t'(1);
        result  = ctr;
        if (taken) begin
            if (ctr != ctr_max) begin
                result = ctr + bp_word_t'(1);
            end
        end else begin
            if (ctr != '0) begin
                result = ctr - bp_word_t'(1);
            end
        end
        return result;
    endfunction

    // PC slice XOR zero-extended global history, masked to the table size.
    function automatic bp_word_t bp_idx(
        input bp_word_t    pc,
        input bp_word_t    ghr,
        input int unsigned pc_lsb,
        input int unsigned idx_bits
    );
        bp_word_t mask;
        mask = (bp_word_t'(1) << idx_bits) - bp_word_t'(1);
        return ((pc >> pc_lsb) ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/bp_sat_stat_counter.sv
// Saturating event counter: counts up on i_inc and sticks at all-ones.
module bp_sat_stat_counter #(
    parameter int unsigned STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [STAT_BITS-1:0] o_count
);

    logic [STAT_BITS-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + STAT_BITS'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters with optional gshare indexing,
// a registered predict port, a retire-time update port and accuracy statistics.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter  int unsigned ENTRIES   = 64,
    parameter  int unsigned CTR_BITS  = 2,
    parameter  int unsigned PC_BITS   = 32,
    parameter  int unsigned PC_LSB    = 2,
    parameter  int unsigned GHR_BITS  = 0,
    parameter  int unsigned STAT_BITS = 16,
    localparam int unsigned IDX_BITS  = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_pred_valid,
    input  logic [PC_BITS-1:0]   i_pred_pc,
    output logic                 o_pred_out_valid,
    output logic                 o_pred_taken,
    output logic [IDX_BITS-1:0]  o_pred_idx,
    input  logic                 i_upd_valid,
    input  logic [IDX_BITS-1:0]  i_upd_idx,
    input  logic                 i_upd_taken,
    output logic [STAT_BITS-1:0] o_stat_updates,
    output logic [STAT_BITS-1:0] o_stat_mispredicts
);

    localparam int unsigned GHR_W = (GHR_BITS == 0) ? 1 : GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] r_table [ENTRIES];
    logic                r_pred_valid;
    logic                r_pred_taken;
    logic [IDX_BITS-1:0] r_pred_idx;

    logic [GHR_W-1:0]    w_ghr;
    logic [IDX_BITS-1:0] w_pred_idx;
    logic [CTR_BITS-1:0] w_pred_ctr;
    logic [CTR_BITS-1:0] w_upd_ctr_old;
    logic [CTR_BITS-1:0] w_upd_ctr_next;
    logic                w_mispredict;

    // History only advances on resolved branches, so prediction never sees wrong-path outcomes.
    generate
        if (GHR_BITS == 0) begin : g_bimodal
            assign w_ghr = '0;
        end else begin : g_gshare
            logic [GHR_W-1:0] r_ghr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (i_upd_valid) begin
                    r_ghr <= GHR_W'({r_ghr, i_upd_taken});
                end
            end

            assign w_ghr = r_ghr;
        end
    endgenerate

    assign w_pred_idx = IDX_BITS'(bp_idx(bp_word_t'(i_pred_pc), bp_word_t'(w_ghr),
                                         PC_LSB, IDX_BITS));

    assign w_upd_ctr_old  = r_table[i_upd_idx];
    assign w_upd_ctr_next = CTR_BITS'(sat_ctr_next(bp_word_t'(w_upd_ctr_old),
                                                   i_upd_taken, CTR_BITS));
    assign w_mispredict   = w_upd_ctr_old[CTR_BITS-1] != i_upd_taken;

    // Same-index update in this cycle is forwarded so the prediction sees the new count.
    assign w_pred_ctr = (i_upd_valid && (i_upd_idx == w_pred_idx)) ? w_upd_ctr_next
                                                                   : r_table[w_pred_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_table[IDX_BITS'(i)] <= CTR_INIT;
            end
        end else if (i_upd_valid) begin
            r_table[i_upd_idx] <= w_upd_ctr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
        end else begin
            r_pred_valid <= i_pred_valid;
            if (i_pred_valid) begin
                r_pred_taken <= w_pred_ctr[CTR_BITS-1];
                r_pred_idx   <= w_pred_idx;
            end
        end
    end

    assign o_pred_out_valid = r_pred_valid;
    assign o_pred_taken     = r_pred_taken;
    assign o_pred_idx       = r_pred_idx;

    bp_sat_stat_counter #(
        .STAT_BITS (STAT_BITS)
    ) u_stat_updates (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (i_upd_valid),
        .o_count (o_stat_updates)
    );

    bp_sat_stat_counter #(
        .STAT_BITS (STAT_BITS)
    ) u_stat_mispredicts (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (i_upd_valid && w_mispredict),
        .o_count (o_stat_mispredicts)
    );

endmodule
